// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg
// Shared types and build-time defaults for the main-memory responder.
//   MEMORY_WIDTH   : default line width in bits (overridable on the command line)
//   MEMORY_LATENCY : default request-to-ack latency shared with the benches
//   mr_state_t     : responder FSM encoding (MR_IDLE / MR_BUSY / MR_ACK)
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif
`ifndef MEMORY_LATENCY
`define MEMORY_LATENCY 10
`endif

package memory_responder_pkg;

  typedef enum logic [1:0] {
    MR_IDLE = 2'b00,
    MR_BUSY = 2'b01,
    MR_ACK  = 2'b10
  } mr_state_t;

  // Width of a counter that must hold values up to n-1 (never zero bits).
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_array.sv
// memory_array
// Single-port synchronous line store, DEPTH x WIDTH, with a registered read.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset (read register only;
//                    the storage itself is never cleared)
//   we, re         : write / read strobes, at most one per access
//   rd_zero        : force the read register to zero instead of loading a line
//   idx            : line index
//   wdata          : write data
//   rdata          : read register; holds its value until the next read strobe
module memory_array #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic             rd_zero,
  input  logic [IW-1:0]    idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= rd_zero ? '0 : mem[idx];
  end

endmodule

// File: rtl/memory_responder.sv
// memory_responder
// Main-memory responder for the four-phase mem_* handshake. One line-wide
// read or write is accepted at a time and acknowledged LATENCY edges after
// the request is first sampled.
//
// Handshake: the initiator raises mem_enable with mem_rw/mem_addr/mem_data_in
// and holds it until it sees mem_ack; mem_ack then stays high until
// mem_enable is sampled low, after which the responder is idle again on the
// following edge. Dropping mem_enable before the ack aborts the request.
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   mem_enable        : request valid, held until mem_ack
//   mem_rw            : 1 = read, 0 = write
//   mem_addr          : byte address; offset bits within a line are ignored
//   mem_data_in       : write data
//   mem_ack           : completion, held until mem_enable falls
//   mem_data_out      : last read data; changes only on a read completion
//   mem_err           : sticky out-of-range flag
//   fsm_state         : current FSM state for observation
//
// Build option: define MEMORY_BOUNDS_EN to drop/zero accesses whose line
// number is >= DEPTH and flag them on mem_err; otherwise addresses wrap
// modulo DEPTH and mem_err is tied low.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WIDTH   = `MEMORY_WIDTH,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = `MEMORY_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_enable,
  input  logic             mem_rw,
  input  logic [31:0]      mem_addr,
  input  logic [WIDTH-1:0] mem_data_in,
  output logic             mem_ack,
  output logic [WIDTH-1:0] mem_data_out,
  output logic             mem_err,
  output logic [1:0]       fsm_state
);

  localparam int OFF = $clog2(WIDTH / 8);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = cnt_bits(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mr_state_t        state, next_state;
  logic [CW-1:0]    cnt;
  logic             rw_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] data_q;
  logic             oob_q;

  logic [IW-1:0]    req_idx;
  logic             req_oob;
  logic             unused_addr;

  assign req_idx     = mem_addr[OFF +: IW];
  assign unused_addr = ^mem_addr;

`ifdef MEMORY_BOUNDS_EN
  logic [31:0] line_num;
  assign line_num = mem_addr >> OFF;
  assign req_oob  = (line_num >= 32'(DEPTH));
`else
  assign req_oob  = 1'b0;
`endif

  // Access strobe and its operands. With LATENCY == 1 the access happens on
  // the accept edge, so the live inputs are used; otherwise the latched copy.
  logic             acc_fire;
  logic             acc_rw;
  logic             acc_oob;
  logic [IW-1:0]    acc_idx;
  logic [WIDTH-1:0] acc_data;

  always_comb begin
    acc_fire = 1'b0;
    acc_rw   = rw_q;
    acc_oob  = oob_q;
    acc_idx  = idx_q;
    acc_data = data_q;
    if (state == MR_IDLE) begin
      acc_rw   = mem_rw;
      acc_oob  = req_oob;
      acc_idx  = req_idx;
      acc_data = mem_data_in;
      acc_fire = mem_enable && (LATENCY == 1);
    end else if (state == MR_BUSY) begin
      acc_fire = mem_enable && (cnt == CNT_ONE);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MR_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      MR_IDLE: begin
        if (mem_enable) begin
          if (LATENCY == 1) next_state = MR_ACK;
          else              next_state = MR_BUSY;
        end
      end
      MR_BUSY: begin
        if (!mem_enable)          next_state = MR_IDLE;
        else if (cnt == CNT_ONE)  next_state = MR_ACK;
      end
      MR_ACK: begin
        if (!mem_enable) next_state = MR_IDLE;
      end
      default: next_state = MR_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem_ack   = (state == MR_ACK);
    fsm_state = state;
  end

  // Request latches and latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      rw_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      oob_q  <= 1'b0;
    end else if (state == MR_IDLE && mem_enable) begin
      cnt    <= CNT_LOAD;
      rw_q   <= mem_rw;
      idx_q  <= req_idx;
      data_q <= mem_data_in;
      oob_q  <= req_oob;
    end else if (state == MR_BUSY && mem_enable && cnt != CNT_ONE) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef MEMORY_BOUNDS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   mem_err <= 1'b0;
    else if (acc_fire && acc_oob) mem_err <= 1'b1;
  end
`else
  assign mem_err = 1'b0;
`endif

  memory_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (acc_fire && !acc_rw && !acc_oob),
    .re      (acc_fire && acc_rw),
    .rd_zero (acc_oob),
    .idx     (acc_idx),
    .wdata   (acc_data),
    .rdata   (mem_data_out)
  );

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  localparam int W   = 128;
  localparam int LAT = 4;

`ifdef MEMORY_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          mem_enable;
  logic          mem_rw;
  logic [31:0]   mem_addr;
  logic [W-1:0]  mem_data_in;
  logic          mem_ack;
  logic [W-1:0]  mem_data_out;
  logic          mem_err;
  logic [1:0]    fsm_state;

  memory_responder #(
    .WIDTH   (W),
    .DEPTH   (4096),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_ack      (mem_ack),
    .mem_data_out (mem_data_out),
    .mem_err      (mem_err),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  logic [W-1:0] last_rd = '0;
  logic         err_exp = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edges at which the enable was sampled high, restarting when it is low.
  int lat_cnt = 0;
  always @(posedge clk) lat_cnt <= mem_enable ? lat_cnt + 1 : 0;

  // Monitor: every rising mem_ack pops one expectation.
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_ack && !ack_prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack with no request outstanding, expected none");
      end else begin
        logic [W-1:0] e;
        logic         ee;
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        check("ack_data", mem_data_out, e);
        check("ack_err", W'(mem_err), W'(ee));
        check("ack_latency", W'(lat_cnt), W'(LAT));
      end
    end
    ack_prev = mem_ack;
  end

  // ---------------- driver ----------------
  // Starts just after a rising edge; returns just after the edge at which the
  // dropped enable was sampled, so consecutive calls are back-to-back.
  task automatic do_req(input logic rw, input logic [31:0] addr,
                        input logic [W-1:0] wdata, input logic [W-1:0] rd_exp,
                        input int hold);
    logic [W-1:0] out_exp;
    bit got;
    if (rw) last_rd = rd_exp;
    out_exp = last_rd;
    exp_q.push_back(out_exp);
    exp_err_q.push_back(err_exp);
    mem_enable  = 1'b1;
    mem_rw      = rw;
    mem_addr    = addr;
    mem_data_in = wdata;
    // Once accepted, the request fields must no longer matter.
    @(posedge clk); #1;
    mem_rw      = ~rw;
    mem_addr    = ~addr;
    mem_data_in = ~wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = mem_ack;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack in 20 cycles for addr %h, expected ack", addr);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ack", W'(mem_ack), W'(1));
      check("hold_data", mem_data_out, out_exp);
    end
    @(posedge clk); #1;
    mem_enable = 1'b0;
    @(posedge clk); #1;
    check("ack_fall", W'(mem_ack), W'(0));
  endtask

  localparam logic [W-1:0] V1  = 128'hDEADBEEF_0000_0001_CAFE_F00D_1234_5678;
  localparam logic [W-1:0] V3  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] V4A = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [W-1:0] V4B = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [W-1:0] V5  = 128'h5A5A_0000_FFFF_1234_8765_4321_C3C3_9999;
  localparam logic [W-1:0] V6A = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [W-1:0] V6B = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    mem_enable  = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", W'(mem_ack), W'(0));
    check("rst_data", mem_data_out, '0);
    check("rst_err", W'(mem_err), W'(0));
    check("rst_state", W'(fsm_state), W'(2'b00));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Write then read the same line at a different byte offset.
    do_req(1'b0, 32'h0000_0100, V1, '0, 0);
    do_req(1'b1, 32'h0000_010C, '0, V1, 0);

    // Abort after two sampled-high edges: no ack, data retained.
    @(posedge clk); #1;
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_addr   = 32'h0000_0200;
    repeat (2) @(posedge clk);
    #1 mem_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", W'(mem_ack), W'(0));
    end
    check("abort_data_kept", mem_data_out, V1);
    @(posedge clk); #1;
    do_req(1'b1, 32'h0000_0104, '0, V1, 0);

    // Held enable after a read ack.
    do_req(1'b0, 32'h0000_0500, V3, '0, 0);
    do_req(1'b1, 32'h0000_0500, '0, V3, 5);

    // Back-to-back write then read.
    do_req(1'b0, 32'h0000_0400, V5, '0, 0);
    do_req(1'b1, 32'h0000_0408, '0, V5, 0);

    // Reset during a BUSY write: prior line contents survive.
    do_req(1'b0, 32'h0000_0300, V4A, '0, 0);
    mem_enable  = 1'b1;
    mem_rw      = 1'b0;
    mem_addr    = 32'h0000_0300;
    mem_data_in = V4B;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_enable = 1'b0;
    #1;
    check("busy_rst_ack", W'(mem_ack), W'(0));
    check("busy_rst_state", W'(fsm_state), W'(2'b00));
    check("busy_rst_data", mem_data_out, '0);
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    do_req(1'b1, 32'h0000_0300, '0, V4A, 0);

    // Out-of-range line index 4096.
    check("pre_oob_err", W'(mem_err), W'(0));
    do_req(1'b0, 32'h0000_0000, V6A, '0, 0);
    err_exp = BOUNDS;
    do_req(1'b0, 32'h0001_0000, V6B, '0, 0);
    do_req(1'b1, 32'h0000_0000, '0, BOUNDS ? V6A : V6B, 0);
    do_req(1'b1, 32'h0001_0004, '0, BOUNDS ? '0 : V6B, 0);
    check("oob_err_final", W'(mem_err), W'(err_exp));

    repeat (3) @(posedge clk);
    check("queue_drain", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
